// File: rtl/uart_tx_serializer_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer_pkg
// Shared definitions for the one-wire serial link transmitter. The receiver
// imports the same package so both ends agree on the frame format.
//   uart_state_e          : transmitter FSM states
//   LINE_IDLE/START_LEVEL/STOP_LEVEL : line levels
//   DEFAULT_*             : default frame geometry shared by both link ends
// ---------------------------------------------------------------------------
package uart_tx_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  localparam int unsigned DEFAULT_DATA_BITS    = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 1;
  localparam int unsigned DEFAULT_STOP_BITS    = 1;

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Bit-period timer for the serial transmitter. Counts down from
// CLKS_PER_BIT-1 and flags the final clock of every bit period.
//   clk_i     : clock
//   rst_i     : synchronous active-low reset
//   restart_i : reload the counter so the next cycle starts a fresh bit
//   enable_i  : count while a frame is on the line
//   bitEnd_o  : high on the last clock of the current bit period
// ---------------------------------------------------------------------------
module uart_baud_tick
  import uart_tx_serializer_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  input  logic enable_i,
  output logic bitEnd_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // With CLKS_PER_BIT=1 the reload value is 0, so every enabled cycle ends a bit.
  assign bitEnd_o = enable_i && (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (restart_i || bitEnd_o) begin
      cnt_q <= RELOAD;
    end else if (enable_i) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
// Transmit side of the one-wire serial link. Takes a byte over valid/ready
// and sends start bit (0), DATA_BITS data bits LSB first, STOP_BITS stop
// bits (1). The line idles high.
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset
//   tx_data  : byte to send, sampled on the accept edge only
//   tx_valid : tx_data is valid
//   tx_ready : a byte can be accepted this cycle
//   tx       : registered serial line
//   busy     : a frame is on the line
//   done     : pulse in the last cycle of the final stop bit
// ---------------------------------------------------------------------------
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = DEFAULT_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic LAST_STOP_BIT = 1'(STOP_BITS - 1);

  uart_state_e            state_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   shift_d;
  logic [BIT_CNT_W-1:0]   bitCnt_q;
  logic                   stopCnt_q;
  logic                   tx_q;
  logic                   bitEnd;
  logic                   lastStop;
  logic                   accept;

  // The timer is held in reload while idle so the first start cycle after an
  // accept always gets a full bit period.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i    (clk),
    .rst_i    (rst),
    .restart_i(state_q == IDLE),
    .enable_i (state_q != IDLE),
    .bitEnd_o (bitEnd)
  );

  assign lastStop = (state_q == STOP) && bitEnd && (stopCnt_q == LAST_STOP_BIT);
  // Ready depends on registered state only, never on tx_valid.
  assign tx_ready = (state_q == IDLE) || lastStop;
  assign accept   = tx_valid && tx_ready;
  assign shift_d  = shift_q >> 1;

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);
  assign done = lastStop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      tx_q      <= LINE_IDLE;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      stopCnt_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_q <= LINE_IDLE;
          if (accept) begin
            shift_q <= tx_data;
            tx_q    <= START_LEVEL;
            state_q <= START;
          end
        end
        START: begin
          if (bitEnd) begin
            tx_q     <= shift_q[0];
            bitCnt_q <= '0;
            state_q  <= DATA;
          end
        end
        DATA: begin
          // tx is registered, so the next bit is taken from the shifted value.
          if (bitEnd) begin
            shift_q <= shift_d;
            if (bitCnt_q == LAST_DATA_BIT) begin
              tx_q      <= STOP_LEVEL;
              stopCnt_q <= 1'b0;
              state_q   <= STOP;
            end else begin
              tx_q     <= shift_d[0];
              bitCnt_q <= bitCnt_q + BIT_CNT_W'(1);
            end
          end
        end
        STOP: begin
          if (lastStop) begin
            if (accept) begin
              shift_q <= tx_data;
              tx_q    <= START_LEVEL;
              state_q <= START;
            end else begin
              tx_q    <= LINE_IDLE;
              state_q <= IDLE;
            end
          end else if (bitEnd) begin
            stopCnt_q <= stopCnt_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= LINE_IDLE;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
